mem_stream_reader: RTL and testbench
====================================

# mem_stream_reader

Read-side streamer for `mem_sys`. On a start command it walks one memory bank, selected by `sel`, from a base address for a given element count. It absorbs the memory's one-cycle registered read latency and delivers the bits in order on a valid/ready stream to the compute datapath. It replaces hand-sequenced read-back, where address N returns data one cycle later, with a flow-controlled engine that has full throughput and never drops a bit.

## Interface
- `ADDR_LEN`, 20, memory address width (weights 20; inputs use 10)
- `SEL_LEN`, 2, bank-select width
- `DATA_LEN`, 1, memory word width
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  command strobe; sampled only in IDLE
- `sel_in`  in  SEL_LEN  bank to read; latched on accepted start
- `base_addr`  in  ADDR_LEN  first address; latched on accepted start
- `len`  in  ADDR_LEN+1  number of elements; latched on accepted start
- `busy`  out  1  high from accepted start until the final handshake
- `done`  out  1  one-cycle pulse on completion
- `mem_addr`  out  ADDR_LEN  to `address_w`/`address_x`
- `mem_sel`  out  SEL_LEN  to `sel_w`/`sel_x`
- `mem_we`  out  1  to `we_w`/`we_x`; constant 0
- `mem_data`  in  DATA_LEN  from `data_out_w`/`data_out_x`; valid the cycle after `mem_addr` is presented
- `out_data`  out  DATA_LEN  stream payload
- `out_valid`  out  1  payload valid
- `out_ready`  in  1  consumer accepts the payload
- `out_last`  out  1  qualifies the final element of the command

## Operation
- FSM: IDLE -> RUN on `start`. RUN -> IDLE on handshake with `out_last`, or after one cycle if `len`==0.
- A `start` received while `busy` is ignored. No queueing of commands.
- Read issue in RUN happens when `issued < len` and `fifo_count + pending < 3`. `pending` (0..2) counts reads issued but not yet captured. On issue, `mem_addr` is driven to the current pointer and the pointer increments.
- Address arithmetic is modulo 2^ADDR_LEN. `base_addr + len` beyond the top wraps to 0.
- Capture: `mem_data` is written to a 3-entry FIFO two edges after issue. The FIFO head drives `out_data`, and `out_valid = fifo_count != 0`.
- Handshake occurs when `out_valid & out_ready` are high at the edge; it pops the head. `out_data`, `out_valid` and `out_last` are held stable while `out_valid & !out_ready`.
- `out_last` is high when the head is element `len-1`.
- The credit rule guarantees FIFO overflow is impossible. Simultaneous capture and pop in the same edge keeps the count unchanged.
- `len`==0: no reads are issued. `done` pulses one cycle after start and `busy` falls with it.
- `done` and the fall of `busy` occur on the edge of the final handshake and are visible in the following cycle.
- Reset mid-command aborts immediately: FIFO, pending count, pointer and FSM are cleared. There are no residual outputs.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_addr`=0, `mem_sel`=0, `mem_we`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
- `start` is accepted at edge E0. `mem_addr`=base is driven after E0, and `mem_data`(base) is present after E1.
- First `out_valid` occurs after E2, giving a latency of 2 cycles.
- With `out_ready` held high, the block delivers 1 element per cycle. A command of N elements completes with `done` N+2 cycles after E0.
- Backpressure cost: issue restarts the cycle after space frees. Once the pipe refills, throughput returns to 1 element per cycle with no bubble.

## Configuration
- `STREAM_POPCNT_EN`: when defined, adds output `popcnt` of width ADDR_LEN+1. It is cleared on accepted start and increments by 1 on each handshake where `out_data[0]`=1. This supports the XNOR-popcount layer, and its value is final when `done` pulses. Reset value is 0.
- When the macro is undefined, the `popcnt` port and its counter are absent and behaviour is otherwise identical.

## Test plan
- Bank `sel`=0 preloaded 1,0,1,1,0,0,1,0,1,1 at 0..9. Command start base=0 len=10 with `out_ready`=1 must produce the stream 1011001011 on consecutive cycles. `out_last` is high on the 10th element, `done` arrives 12 cycles after start, and `popcnt`=6 if enabled.
- Same command with `out_ready` toggling 1,0,0,1 repeating: the identical bit sequence is delivered with no drop or duplicate, and data is held stable during stalls.
- `sel`=2, base=2^20-2, len=4: addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001 are read in order and `mem_sel`=2 for the whole command.
- len=0: `busy` goes high for 1 cycle and `done` pulses. No `out_valid` is asserted, and `mem_addr` never leaves the base.
- `start` reasserted mid-command is ignored. Asserting `rst` low after the 5th element of a 10-element command gives all outputs at reset values in the same cycle. A following start base=0 len=3 streams 1,0,1.

Source files
------------

// File: rtl/mem_stream_reader.sv
// Read-side streamer: walks one memory bank and delivers its words on a valid/ready stream.
// Optional STREAM_POPCNT_EN adds a popcount of out_data[0] over the handshakes of a command.
module mem_stream_reader #(
  parameter int ADDR_LEN = 20,
  parameter int SEL_LEN  = 2,
  parameter int DATA_LEN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SEL_LEN-1:0]  sel_in,
  input  logic [ADDR_LEN-1:0] base_addr,
  input  logic [ADDR_LEN:0]   len,
  output logic                busy,
  output logic                done,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [SEL_LEN-1:0]  mem_sel,
  output logic                mem_we,
  input  logic [DATA_LEN-1:0] mem_data,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
`ifdef STREAM_POPCNT_EN
  output logic [ADDR_LEN:0]   popcnt,
`endif
  output logic                state_dbg
);

  // Valid/ready: a payload transfers on every rising edge where out_valid and out_ready
  // are both high; while out_valid is high and out_ready low, payload and last are held.

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [ADDR_LEN-1:0] ONE_A = 1;
  localparam logic [ADDR_LEN:0]   ONE_L = 1;

  state_t              state_q, state_d;
  logic [SEL_LEN-1:0]  sel_q, sel_d;
  logic [ADDR_LEN-1:0] ptr_q, ptr_d;
  logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_LEN:0]   len_q, len_d;
  logic [ADDR_LEN:0]   issued_q, issued_d;
  logic [ADDR_LEN:0]   popped_q, popped_d;
  logic                v1_q, v1_d;   // read address presented, memory samples it next edge
  logic                v2_q, v2_d;   // read data on mem_data, captured next edge
  logic [DATA_LEN-1:0] fifo_q [3];
  logic [DATA_LEN-1:0] fifo_d [3];
  logic [1:0]          wr_q, wr_d;
  logic [1:0]          rd_q, rd_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [ADDR_LEN:0]   popcnt_q, popcnt_d;

  logic                hs;
  logic                issue;
  logic [2:0]          occ;

  always_comb begin
    out_valid = (cnt_q != 2'd0);
    out_data  = out_valid ? fifo_q[rd_q] : '0;
    out_last  = out_valid && (popped_q == (len_q - ONE_L));
    hs        = out_valid && out_ready;
    // Slots committed after this edge; a pop on the same edge frees its slot for a new issue.
    occ       = {1'b0, cnt_q} + {2'b00, v1_q} + {2'b00, v2_q} - {2'b00, hs};
    issue     = (state_q == S_RUN) && (issued_q < len_q) && (occ < 3'd3);

    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    mem_addr_d = mem_addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    fifo_d     = fifo_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    done_d     = 1'b0;
    popcnt_d   = popcnt_q;
    v1_d       = 1'b0;
    v2_d       = v1_q;
    cnt_d      = cnt_q + {1'b0, v2_q} - {1'b0, hs};

    if (v2_q) begin
      fifo_d[wr_q] = mem_data;
      wr_d         = (wr_q == 2'd2) ? 2'd0 : wr_q + 2'd1;
    end
    if (hs) begin
      rd_d     = (rd_q == 2'd2) ? 2'd0 : rd_q + 2'd1;
      popped_d = popped_q + ONE_L;
      if (out_data[0]) popcnt_d = popcnt_q + ONE_L;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          sel_d      = sel_in;
          len_d      = len;
          mem_addr_d = base_addr;
          popped_d   = '0;
          popcnt_d   = '0;
          if (len != '0) begin
            ptr_d    = base_addr + ONE_A;
            issued_d = ONE_L;
            v1_d     = 1'b1;
          end else begin
            ptr_d    = base_addr;
            issued_d = '0;
          end
        end
      end
      default: begin
        if (issue) begin
          mem_addr_d = ptr_q;
          ptr_d      = ptr_q + ONE_A;
          issued_d   = issued_q + ONE_L;
          v1_d       = 1'b1;
        end
        if ((len_q == '0) || (hs && out_last)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      mem_addr_q <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
      wr_q       <= 2'd0;
      rd_q       <= 2'd0;
      cnt_q      <= 2'd0;
      done_q     <= 1'b0;
      popcnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      mem_addr_q <= mem_addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      for (int i = 0; i < 3; i++) fifo_q[i] <= fifo_d[i];
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      popcnt_q   <= popcnt_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_sel   = sel_q;
  assign mem_we    = 1'b0;
  assign state_dbg = state_q;
`ifdef STREAM_POPCNT_EN
  assign popcnt    = popcnt_q;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomized bench for mem_stream_reader against a queue-based stream model and a hashed memory.
// Build with STREAM_POPCNT_EN defined to also check the popcount output.
module tb_mem_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  sel_in;
  logic [19:0] base_addr;
  logic [20:0] len;
  logic        busy, done, mem_we, out_valid, out_last, state_dbg;
  logic [19:0] mem_addr;
  logic [1:0]  mem_sel;
  logic [0:0]  mem_data = 1'b0;
  logic [0:0]  out_data;
  logic        out_ready = 1'b1;
`ifdef STREAM_POPCNT_EN
  logic [20:0] popcnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int n_rx   = 0;
  int cyc    = 0;
  int rdy_mode = 0;
  bit mon_en = 1'b0;
  bit stall_prev = 1'b0;
  logic [0:0] prev_data;
  logic       prev_last;
  logic [0:0] exp_q[$];
  logic [0:9] pat_v = 10'b1011001011;

  always #5 clk = ~clk;

  mem_stream_reader dut (
    .clk(clk), .rst(rst_n), .start(start), .sel_in(sel_in), .base_addr(base_addr),
    .len(len), .busy(busy), .done(done), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_we(mem_we), .mem_data(mem_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
`ifdef STREAM_POPCNT_EN
    .popcnt(popcnt),
`endif
    .state_dbg(state_dbg)
  );

  // Bank 0 holds the preload pattern at 0..9; every other location is a fixed hash.
  function automatic logic [0:0] mem_bit(input logic [1:0] s, input logic [19:0] a);
    logic [31:0] h;
    if (s == 2'd0 && a < 20'd10) return pat_v[a];
    h = ({12'b0, a} * 32'h9E3779B1) ^ ({30'b0, s} * 32'h7F4A7C15);
    return h[17];
  endfunction

  always @(posedge clk) mem_data <= mem_bit(mem_sel, mem_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Consumer: drives out_ready for the coming edge, then scores the handshake it implies.
  always @(negedge clk) begin
    cyc++;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (mon_en) begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid && exp_q.size() == 0) chk("extra_valid", out_valid, 0);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        chk("last", out_last, exp_q.size() == 1);
        chk("data", out_data, exp_q.pop_front());
        n_rx++;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_sel"}, mem_sel, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_data"}, out_data, 0);
`ifdef STREAM_POPCNT_EN
    chk({tag, "_popcnt"}, popcnt, 0);
`endif
  endtask

  task automatic load_exp(input logic [1:0] s, input logic [19:0] b, input int n, output int ones);
    logic [19:0] a;
    exp_q.delete();
    ones = 0;
    for (int i = 0; i < n; i++) begin
      a = b + 20'(i);
      exp_q.push_back(mem_bit(s, a));
      ones += int'(mem_bit(s, a));
    end
  endtask

  task automatic run_cmd(input logic [1:0] s, input logic [19:0] b, input int n,
                         input int mode, input bit poke);
    logic [19:0] a_log[$];
    logic [19:0] last_a;
    logic [19:0] a;
    int k, ones, exp_lat, exp_addrs;
    bit sel_ok;
    load_exp(s, b, n, ones);
    rdy_mode = mode;
    mon_en   = 1'b1;
    @(negedge clk);
    sel_in = s; base_addr = b; len = 21'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("sel_latch", mem_sel, s);
    a_log.push_back(mem_addr);
    last_a = mem_addr;
    sel_ok = 1'b1;
    k = 0;
    while (!done && k < n + 200) begin
      @(posedge clk); #1;
      k++;
      if (busy && mem_sel != s) sel_ok = 1'b0;
      if (mem_we) sel_ok = 1'b0;
      if (mem_addr != last_a) begin
        a_log.push_back(mem_addr);
        last_a = mem_addr;
      end
      if (poke && k == 3) begin
        start = 1'b1; base_addr = ~b; len = 21'd5; sel_in = ~s;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    exp_lat   = (n == 0) ? 1 : n + 2;
    exp_addrs = (n == 0) ? 1 : n;
    chk("done_seen", done, 1);
    if (mode == 0) chk("done_lat", k, exp_lat);
    chk("busy_fall", busy, 0);
    chk("all_rx", exp_q.size(), 0);
    chk("sel_we_hold", sel_ok, 1);
    chk("addr_cnt", a_log.size(), exp_addrs);
    for (int i = 0; i < exp_addrs && i < a_log.size(); i++) begin
      a = b + 20'(i);
      chk("addr_seq", a_log[i], a);
    end
`ifdef STREAM_POPCNT_EN
    chk("popcnt", popcnt, ones);
`endif
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0, k, ones, n;
    logic [19:0] b;
    rst_n = 1'b0; start = 1'b0; sel_in = 2'd0; base_addr = 20'd0; len = 21'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    run_cmd(2'd0, 20'd0, 10, 0, 1'b0);        // 1011001011 at full rate
    run_cmd(2'd0, 20'd0, 10, 1, 1'b1);        // ready 1,0,0,1 and an ignored start mid-command
    run_cmd(2'd2, 20'hFFFFE, 4, 0, 1'b0);     // wraps through the top of the address space
    run_cmd(2'd1, 20'h12345, 0, 0, 1'b0);     // empty command
    run_cmd(2'd3, 20'hFFFFF, 1, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      b = (t % 2 == 0) ? 20'($urandom_range(0, 20'hFFFFF)) : 20'hFFFFF - 20'($urandom_range(0, 6));
      n = $urandom_range(1, 16);
      run_cmd(2'($urandom_range(0, 3)), b, n, (t == 3) ? 0 : 2, 1'b0);
    end

    // Reset after the 5th element of a 10-element command aborts it at once.
    load_exp(2'd0, 20'd0, 10, ones);
    rdy_mode = 0;
    mon_en = 1'b1;
    rx0 = n_rx;
    @(negedge clk);
    sel_in = 2'd0; base_addr = 20'd0; len = 21'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while ((n_rx - rx0) < 5 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("abort_rx5", n_rx - rx0, 5);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(2'd0, 20'd0, 3, 0, 1'b0);         // streams 1,0,1

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
